gmii_tx_p1_arbiter: RTL and testbench



---
 rtl/gmii_tx_p1_arbiter_pkg.sv | 26 ++
 rtl/gmii_tx_p1_arbiter_if.sv | 26 ++
 rtl/gmii_frame_len_mon.sv | 58 +++++
 rtl/gmii_tx_p1_arbiter.sv | 168 ++++++++++++++++
 tb/tb_gmii_tx_p1_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gmii_tx_p1_arbiter_pkg.sv
// Shared definitions for the port GMII TX arbiters: FSM encoding, frame
// timing defaults and a saturating counter helper.
package gmii_tx_p1_arbiter_pkg;

    localparam int IFG_BYTES       = 12;
    localparam int MIN_FRAME_BYTES = 72;
    localparam int MAX_FRAME_BYTES = 1530;
    localparam int GRANT_TIMEOUT   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XMIT  = 2'd2,
        ST_IFG   = 2'd3
    } arb_state_t;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/gmii_tx_p1_arbiter_if.sv
// Request/grant handshake of the two frame sources plus the GMII TX pins.
// The arbiter is the slave side; the sources and the PHY pins form the master side.
interface gmii_tx_p1_arbiter_if;
    logic       ts_req;
    logic       ts_grant;
    logic       ts_dv;
    logic [7:0] ts_txd;
    logic       be_req;
    logic       be_grant;
    logic       be_dv;
    logic [7:0] be_txd;
    logic       be_gate_open;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;

    modport master (
        output ts_req, ts_dv, ts_txd, be_req, be_dv, be_txd, be_gate_open,
        input  ts_grant, be_grant, gmii_txd, gmii_tx_en, gmii_tx_er
    );

    modport slave (
        input  ts_req, ts_dv, ts_txd, be_req, be_dv, be_txd, be_gate_open,
        output ts_grant, be_grant, gmii_txd, gmii_tx_en, gmii_tx_er
    );
endinterface

// File: rtl/gmii_frame_len_mon.sv
// Output register stage for the muxed byte stream. Counts bytes per frame,
// flags runt frames at frame end, and marks every byte beyond the maximum
// length with tx_er.
module gmii_frame_len_mon
    import gmii_tx_p1_arbiter_pkg::*;
#(
    parameter int MIN_LEN = MIN_FRAME_BYTES,
    parameter int MAX_LEN = MAX_FRAME_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dv,
    input  logic [7:0] txd,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       runt,
    output logic       giant
);

    localparam logic [11:0] MIN_LEN_V = 12'(MIN_LEN);
    localparam logic [11:0] MAX_LEN_V = 12'(MAX_LEN);

    logic [11:0] len_r;
    logic [7:0]  txd_r;
    logic        en_r;
    logic        er_r;

    // len_r holds the number of bytes already seen in the current frame.
    // A frame ends on the first dv-low cycle; len_r is then the frame length.
    assign runt  = !dv && (len_r != 12'd0) && (len_r < MIN_LEN_V);
    // Exactly one byte crosses the limit, so this fires once per frame.
    assign giant = dv && (len_r == MAX_LEN_V);

    // Byte counter (held at 4095) plus the single pipeline stage to the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r <= 12'd0;
            txd_r <= 8'h00;
            en_r  <= 1'b0;
            er_r  <= 1'b0;
        end else begin
            if (dv) begin
                len_r <= (len_r == 12'hFFF) ? len_r : len_r + 12'd1;
            end else begin
                len_r <= 12'd0;
            end
            txd_r <= dv ? txd : 8'h00;
            en_r  <= dv;
            er_r  <= dv && (len_r >= MAX_LEN_V);
        end
    end

    assign gmii_txd   = txd_r;
    assign gmii_tx_en = en_r;
    assign gmii_tx_er = er_r;

endmodule

// File: rtl/gmii_tx_p1_arbiter.sv
// Port-1 GMII TX arbiter: whole-frame grants with strict TS priority,
// BE gated by the time slot, minimum inter-frame gap and error counting.
module gmii_tx_p1_arbiter
    import gmii_tx_p1_arbiter_pkg::*;
#(
    parameter int IFG     = IFG_BYTES,
    parameter int MIN_LEN = MIN_FRAME_BYTES,
    parameter int MAX_LEN = MAX_FRAME_BYTES,
    parameter int TIMEOUT = GRANT_TIMEOUT
) (
    input  logic                   o_gmii_tx_clk_p1,
    input  logic                   w_gmii_rst_n_p1,
    gmii_tx_p1_arbiter_if.slave    bus,
    output logic [15:0]            ts_frame_cnt,
    output logic [15:0]            be_frame_cnt,
    output logic [15:0]            err_cnt,
    output logic [1:0]             arb_state
);

    // Gap cycle 0 is the dv-low cycle, so deciding in gap cycle IFG-2 puts
    // the new grant in gap cycle IFG-1 and the first byte on the pins after IFG idles.
    localparam logic [3:0] IFG_DECIDE   = 4'(IFG - 2);
    localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);

    arb_state_t  state_r;
    logic        ts_grant_r;
    logic        be_grant_r;
    logic [4:0]  wait_cnt_r;
    logic [3:0]  ifg_cnt_r;
    logic [15:0] ts_cnt_r;
    logic [15:0] be_cnt_r;
    logic [15:0] err_cnt_r;

    logic        mux_dv_s;
    logic [7:0]  mux_txd_s;
    logic        pick_ts_s;
    logic        pick_be_s;
    logic        timeout_s;
    logic        runt_s;
    logic        giant_s;

    // Only the granted source reaches the datapath; the other dv is ignored.
    always_comb begin
        mux_dv_s  = 1'b0;
        mux_txd_s = 8'h00;
        if (ts_grant_r) begin
            mux_dv_s  = bus.ts_dv;
            mux_txd_s = bus.ts_txd;
        end else if (be_grant_r) begin
            mux_dv_s  = bus.be_dv;
            mux_txd_s = bus.be_txd;
        end else begin
            mux_dv_s  = 1'b0;
            mux_txd_s = 8'h00;
        end
    end

    // Grant decision: TS always wins; the gate matters only at this instant.
    assign pick_ts_s = bus.ts_req;
    assign pick_be_s = !bus.ts_req && bus.be_req && bus.be_gate_open;
    assign timeout_s = (state_r == ST_GRANT) && !mux_dv_s && (wait_cnt_r == TIMEOUT_LAST);

    // Arbitration FSM with registered grants and per-source frame counters.
    always_ff @(posedge o_gmii_tx_clk_p1 or negedge w_gmii_rst_n_p1) begin
        if (!w_gmii_rst_n_p1) begin
            state_r    <= ST_IDLE;
            ts_grant_r <= 1'b0;
            be_grant_r <= 1'b0;
            wait_cnt_r <= 5'd0;
            ifg_cnt_r  <= 4'd0;
            ts_cnt_r   <= 16'd0;
            be_cnt_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_ts_s || pick_be_s) begin
                        ts_grant_r <= pick_ts_s;
                        be_grant_r <= pick_be_s;
                        wait_cnt_r <= 5'd0;
                        state_r    <= ST_GRANT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (mux_dv_s) begin
                        state_r <= ST_XMIT;
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        ts_grant_r <= 1'b0;
                        be_grant_r <= 1'b0;
                        ifg_cnt_r  <= 4'd1;
                        state_r    <= ST_IFG;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 5'd1;
                    end
                end
                ST_XMIT: begin
                    if (!mux_dv_s) begin
                        ts_grant_r <= 1'b0;
                        be_grant_r <= 1'b0;
                        if (ts_grant_r) begin
                            ts_cnt_r <= sat_inc16(ts_cnt_r);
                        end else begin
                            be_cnt_r <= sat_inc16(be_cnt_r);
                        end
                        ifg_cnt_r <= 4'd1;
                        state_r   <= ST_IFG;
                    end else begin
                        state_r <= ST_XMIT;
                    end
                end
                ST_IFG: begin
                    if (ifg_cnt_r == IFG_DECIDE) begin
                        if (pick_ts_s || pick_be_s) begin
                            ts_grant_r <= pick_ts_s;
                            be_grant_r <= pick_be_s;
                            wait_cnt_r <= 5'd0;
                            state_r    <= ST_GRANT;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        ifg_cnt_r <= ifg_cnt_r + 4'd1;
                    end
                end
                default: begin
                    ts_grant_r <= 1'b0;
                    be_grant_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Runt, giant and grant-timeout events are mutually exclusive in a cycle.
    always_ff @(posedge o_gmii_tx_clk_p1 or negedge w_gmii_rst_n_p1) begin
        if (!w_gmii_rst_n_p1) begin
            err_cnt_r <= 16'd0;
        end else if (timeout_s || runt_s || giant_s) begin
            err_cnt_r <= sat_inc16(err_cnt_r);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    gmii_frame_len_mon #(
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN)
    ) u_len_mon (
        .clk        (o_gmii_tx_clk_p1),
        .rst_n      (w_gmii_rst_n_p1),
        .dv         (mux_dv_s),
        .txd        (mux_txd_s),
        .gmii_txd   (bus.gmii_txd),
        .gmii_tx_en (bus.gmii_tx_en),
        .gmii_tx_er (bus.gmii_tx_er),
        .runt       (runt_s),
        .giant      (giant_s)
    );

    assign bus.ts_grant = ts_grant_r;
    assign bus.be_grant = be_grant_r;
    assign ts_frame_cnt = ts_cnt_r;
    assign be_frame_cnt = be_cnt_r;
    assign err_cnt      = err_cnt_r;
    assign arb_state    = state_r;

endmodule

// File: tb/tb_gmii_tx_p1_arbiter.sv
// Scoreboard bench: scenarios push the frames they expect on the wire,
// a free-running monitor compares every output frame against the queue head.
module tb_gmii_tx_p1_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] ts_frame_cnt;
    logic [15:0] be_frame_cnt;
    logic [15:0] err_cnt;
    logic [1:0]  arb_state;

    gmii_tx_p1_arbiter_if bus ();

    gmii_tx_p1_arbiter dut (
        .o_gmii_tx_clk_p1 (clk),
        .w_gmii_rst_n_p1  (rst_n),
        .bus              (bus),
        .ts_frame_cnt     (ts_frame_cnt),
        .be_frame_cnt     (be_frame_cnt),
        .err_cnt          (err_cnt),
        .arb_state        (arb_state)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct {
        int src;        // 0 = TS, 1 = BE
        int len;
        int seed;
        int gap_exact;  // -1: only the minimum gap is checked
        bit abort;      // frame cut by reset: only the bytes seen are checked
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   dv_start[2];
    int   ts_m = 0, be_m = 0, err_m = 0;

    // monitor state
    bit   in_frame = 0;
    bit   have = 0;
    int   idx = 0;
    int   gap_cnt = 1000;
    int   bad_data = 0;
    int   bad_er = 0;
    exp_t cur;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] fbyte(input int seed, input int k);
        int v;
        v = seed * 31 + k * 7 + (k >> 5);
        return v[7:0];
    endfunction

    function automatic bit granted(input int src);
        return (src == 0) ? bus.ts_grant : bus.be_grant;
    endfunction

    task automatic set_req(input int src, input logic v);
        if (src == 0) bus.ts_req = v; else bus.be_req = v;
    endtask

    task automatic set_dv(input int src, input logic v, input logic [7:0] d);
        if (src == 0) begin bus.ts_dv = v; bus.ts_txd = d; end
        else begin bus.be_dv = v; bus.be_txd = d; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Minimum-latency requester: dv in the cycle after grant is first seen.
    task automatic drive(input int src, input int len, input int seed, output int lat);
        set_req(src, 1'b1);
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (granted(src)) break;
            if (lat >= 300) begin
                chk("grant_wait", 1'b0, 64'(lat), 64'd300);
                set_req(src, 1'b0);
                return;
            end
        end
        set_req(src, 1'b0);
        @(posedge clk); #1;
        dv_start[src] = cyc;
        for (int k = 1; k <= len; k++) begin
            set_dv(src, 1'b1, fbyte(seed, k));
            @(posedge clk); #1;
        end
        set_dv(src, 1'b0, 8'h00);
    endtask

    task automatic push(input int src, input int len, input int seed, input int gap, input bit ab);
        exp_t e;
        e.src = src; e.len = len; e.seed = seed; e.gap_exact = gap; e.abort = ab;
        exp_q.push_back(e);
        if (!ab) begin
            if (src == 0) ts_m++; else be_m++;
            if (len < 72 || len > 1530) err_m++;
        end
    endtask

    task automatic check_counters(input string name);
        chk({name, "_ts_cnt"}, ts_frame_cnt == 16'(ts_m), 64'(ts_frame_cnt), 64'(ts_m));
        chk({name, "_be_cnt"}, be_frame_cnt == 16'(be_m), 64'(be_frame_cnt), 64'(be_m));
        chk({name, "_err_cnt"}, err_cnt == 16'(err_m), 64'(err_cnt), 64'(err_m));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: frames are delimited by tx_en and compared against the queue head.
    always @(negedge clk) begin
        if (bus.gmii_tx_en) begin
            if (!in_frame) begin
                in_frame = 1; idx = 0; bad_data = 0; bad_er = 0;
                if (exp_q.size() == 0) begin
                    have = 0;
                    chk("unexpected_frame", 1'b0, 64'd1, 64'd0);
                end else begin
                    have = 1;
                    cur = exp_q[0];
                    chk("gap_min", gap_cnt >= 12, 64'(gap_cnt), 64'd12);
                    if (cur.gap_exact >= 0)
                        chk("gap_exact", gap_cnt == cur.gap_exact, 64'(gap_cnt), 64'(cur.gap_exact));
                    chk("dv_to_en", (cyc - dv_start[cur.src]) == 1, 64'(cyc - dv_start[cur.src]), 64'd1);
                end
            end
            idx++;
            if (have) begin
                if (bus.gmii_txd != fbyte(cur.seed, idx)) bad_data++;
                if (bus.gmii_tx_er != (idx > 1530)) bad_er++;
            end
        end else begin
            if (in_frame) begin
                in_frame = 0;
                if (have) begin
                    void'(exp_q.pop_front());
                    chk("data", bad_data == 0, 64'(bad_data), 64'd0);
                    if (!cur.abort) begin
                        chk("length", idx == cur.len, 64'(idx), 64'(cur.len));
                        chk("tx_er", bad_er == 0, 64'(bad_er), 64'd0);
                    end
                end
                gap_cnt = 0;
            end
            gap_cnt++;
        end
    end

    initial begin
        int lat_a, lat_b, cnt, mode, len;
        logic [63:0] snap;
        rst_n = 1'b0;
        bus.ts_req = 1'b0; bus.ts_dv = 1'b0; bus.ts_txd = 8'h00;
        bus.be_req = 1'b0; bus.be_dv = 1'b0; bus.be_txd = 8'h00;
        bus.be_gate_open = 1'b1;
        dv_start[0] = 0; dv_start[1] = 0;
        idle(3);
        snap = {bus.gmii_txd, bus.gmii_tx_en, bus.gmii_tx_er, bus.ts_grant, bus.be_grant,
                arb_state, ts_frame_cnt, be_frame_cnt, err_cnt};
        chk("reset_state", snap == 64'd0, snap, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // single minimum-length TS frame
        push(0, 72, 1, -1, 0);
        drive(0, 72, 1, lat_a);
        chk("ts_grant_latency", lat_a == 1, 64'(lat_a), 64'd1);
        idle(20);
        check_counters("single_ts");

        // simultaneous requests: TS first, BE after exactly the gap
        push(0, 100, 2, -1, 0);
        push(1, 100, 3, 12, 0);
        fork
            drive(0, 100, 2, lat_a);
            drive(1, 100, 3, lat_b);
        join
        idle(20);
        check_counters("both");

        // gate closed for 50 cycles, then open; closing mid-frame is harmless
        bus.be_gate_open = 1'b0;
        push(1, 100, 4, -1, 0);
        fork
            drive(1, 100, 4, lat_b);
            begin
                cnt = 0;
                repeat (50) begin
                    @(posedge clk); #1;
                    if (bus.be_grant) cnt++;
                end
                chk("gate_closed_grants", cnt == 0, 64'(cnt), 64'd0);
                bus.be_gate_open = 1'b1;
                @(posedge clk); #1;
                chk("gate_open_grant", bus.be_grant == 1'b1, 64'(bus.be_grant), 64'd1);
                repeat (20) @(posedge clk);
                #1 bus.be_gate_open = 1'b0;
            end
        join
        bus.be_gate_open = 1'b1;
        idle(20);
        check_counters("gate");

        // giant then runt frame
        push(1, 1535, 5, -1, 0);
        push(1, 60, 6, -1, 0);
        drive(1, 1535, 5, lat_b);
        drive(1, 60, 6, lat_b);
        idle(20);
        check_counters("giant_runt");

        // TS never raises dv; BE waits behind the timeout and the gap
        push(1, 80, 7, -1, 0);
        err_m++;
        fork
            begin
                bus.ts_req = 1'b1;
                @(posedge clk); #1;
                chk("timeout_ts_grant", bus.ts_grant == 1'b1, 64'(bus.ts_grant), 64'd1);
                chk("state_grant", arb_state == 2'd1, 64'(arb_state), 64'd1);
                bus.ts_req = 1'b0;
                cnt = 0;
                while (bus.ts_grant && cnt < 40) begin
                    cnt++;
                    @(posedge clk); #1;
                end
                chk("timeout_grant_cycles", cnt == 16, 64'(cnt), 64'd16);
            end
            drive(1, 80, 7, lat_b);
        join
        chk("be_after_timeout_latency", lat_b == 27, 64'(lat_b), 64'd27);
        idle(20);
        check_counters("timeout");

        // reset at byte 40 of a TS frame
        push(0, 100, 8, -1, 1);
        fork
            drive(0, 100, 8, lat_a);
            begin
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (in_frame && idx >= 40) break;
                end
                #1 rst_n = 1'b0;
                #1;
                snap = {bus.gmii_txd, bus.gmii_tx_en, bus.gmii_tx_er, bus.ts_grant, bus.be_grant,
                        arb_state, ts_frame_cnt, be_frame_cnt, err_cnt};
                chk("reset_async", snap == 64'd0, snap, 64'd0);
                ts_m = 0; be_m = 0; err_m = 0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk("state_after_reset", arb_state == 2'd0, 64'(arb_state), 64'd0);
            end
        join
        idle(5);
        push(0, 90, 9, -1, 0);
        drive(0, 90, 9, lat_a);
        chk("post_reset_latency", lat_a == 1, 64'(lat_a), 64'd1);
        idle(20);
        check_counters("post_reset");

        // randomized traffic
        for (int it = 0; it < 10; it++) begin
            mode = $urandom_range(0, 2);
            len  = $urandom_range(60, 140);
            if (mode == 0) begin
                push(0, len, 100 + it, -1, 0);
                drive(0, len, 100 + it, lat_a);
            end else if (mode == 1) begin
                push(1, len, 200 + it, -1, 0);
                drive(1, len, 200 + it, lat_b);
            end else begin
                push(0, len, 300 + it, -1, 0);
                push(1, len + 3, 400 + it, 12, 0);
                fork
                    drive(0, len, 300 + it, lat_a);
                    drive(1, len + 3, 400 + it, lat_b);
                join
            end
            idle($urandom_range(0, 15));
        end
        idle(30);
        check_counters("random");
        chk("scoreboard_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
